iq_demodulator: RTL and testbench

Receive-side counterpart of the IQ modulator. It mixes a real, signed sample stream with the same packed cos/sin reference stream to produce baseband I and Q. It then low-pass filters and decimates by DEC_NUM using an integrate-and-dump stage, scales and saturates the result, and presents packed I/Q on an AXI-Stream master with an overflow counter.

---
 rtl/iq_demodulator_if.sv | 12 +
 rtl/iq_demodulator.sv | 132 +++++++++++++
 tb/tb_iq_demodulator.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/iq_demodulator_if.sv
// Stream bundle (data/valid/ready) for the IQ demodulator sample,
// reference and result ports.
interface iq_demodulator_if #(
    parameter int W = 16
) ();
    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tready;

    modport master (output tdata, output tvalid, input  tready);
    modport slave  (input  tdata, input  tvalid, output tready);
endinterface

// File: rtl/iq_demodulator.sv
// IQ demodulator: mixes a real sample stream with a packed cos/sin reference,
// integrates-and-dumps DEC_NUM products, then scales, saturates and presents
// packed {Q,I} on a single-entry output register with an overflow counter.
module iq_demodulator #(
    parameter int DEC_NUM = 10,
    parameter int D_W     = 16,
    parameter int R_W     = 8,
    parameter int O_W     = 16,
    parameter int SHIFT   = 8
) (
    input  logic              clk,
    input  logic              rstn,
    iq_demodulator_if.slave   s_axis,
    iq_demodulator_if.slave   s_axis_ref,
    iq_demodulator_if.master  m_axis,
    output logic [15:0]       overflow_cnt
);
    localparam int M_W   = D_W + R_W;
    localparam int CNT_W = (DEC_NUM > 1) ? $clog2(DEC_NUM) : 1;
    localparam int A_W   = M_W + $clog2(DEC_NUM);

    localparam logic signed [A_W-1:0] SAT_MAX = A_W'({1'b0, {(O_W-1){1'b1}}});
    localparam logic signed [A_W-1:0] SAT_MIN = ~SAT_MAX;

    logic                    r_run;
    logic signed [M_W-1:0]   r_mix_i, r_mix_q;
    logic                    r_mix_vld;
    logic [CNT_W-1:0]        r_cnt;
    logic signed [A_W-1:0]   r_acc_i, r_acc_q;
    logic [2*O_W-1:0]        r_tdata;
    logic                    r_tvalid;
    logic [15:0]             r_ovf;

    logic signed [D_W-1:0]   w_x_raw;
    logic signed [R_W-1:0]   w_cos_raw, w_sin_raw;
    logic signed [M_W-1:0]   w_x, w_cos, w_sin;
    logic                    w_ready, w_accept, w_last, w_dump;
    logic signed [A_W-1:0]   w_sum_i, w_sum_q, w_sh_i, w_sh_q;
    logic [O_W-1:0]          w_y_i, w_y_q;

    // Clip a scaled sum into the signed output range.
    function automatic logic [O_W-1:0] sat(input logic signed [A_W-1:0] v);
        if (v > SAT_MAX)      return SAT_MAX[O_W-1:0];
        else if (v < SAT_MIN) return SAT_MIN[O_W-1:0];
        else                  return v[O_W-1:0];
    endfunction

    // Operands are sign-extended to product width so the multiply is exact.
    assign w_x_raw   = s_axis.tdata[D_W-1:0];
    assign w_cos_raw = s_axis_ref.tdata[R_W-1:0];
    assign w_sin_raw = s_axis_ref.tdata[2*R_W-1:R_W];
    assign w_x       = M_W'(w_x_raw);
    assign w_cos     = M_W'(w_cos_raw);
    assign w_sin     = M_W'(w_sin_raw);

    // Ready never looks at the sample valid; the reference is consumed with the sample.
    assign w_ready  = r_run & s_axis_ref.tvalid;
    assign w_accept = w_ready & s_axis.tvalid;

    assign w_last = (r_cnt == CNT_W'(DEC_NUM - 1));
    assign w_dump = r_mix_vld & w_last;

    // cnt==0 starts a new block, so the stale accumulator is ignored there.
    assign w_sum_i = ((r_cnt == '0) ? '0 : r_acc_i) + A_W'(r_mix_i);
    assign w_sum_q = ((r_cnt == '0) ? '0 : r_acc_q) + A_W'(r_mix_q);
    assign w_sh_i  = w_sum_i >>> SHIFT;
    assign w_sh_q  = w_sum_q >>> SHIFT;
    assign w_y_i   = sat(w_sh_i);
    assign w_y_q   = sat(w_sh_q);

    // Run flag: opens the input one cycle after reset is released.
    always_ff @(posedge clk) begin
        if (!rstn) r_run <= 1'b0;
        else       r_run <= 1'b1;
    end

    // Mix stage: register full-precision products for each accepted sample.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_mix_i   <= '0;
            r_mix_q   <= '0;
            r_mix_vld <= 1'b0;
        end else begin
            r_mix_vld <= w_accept;
            if (w_accept) begin
                r_mix_i <= w_x * w_cos;
                r_mix_q <= w_x * w_sin;
            end
        end
    end

    // Integrate-and-dump: accumulate DEC_NUM products, restart after the last.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_cnt   <= '0;
            r_acc_i <= '0;
            r_acc_q <= '0;
        end else if (r_mix_vld) begin
            if (w_last) begin
                r_cnt   <= '0;
                r_acc_i <= '0;
                r_acc_q <= '0;
            end else begin
                r_cnt   <= r_cnt + CNT_W'(1);
                r_acc_i <= w_sum_i;
                r_acc_q <= w_sum_q;
            end
        end
    end

    // Output register: a new result always wins; a lost unread result is counted.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_tdata  <= '0;
            r_tvalid <= 1'b0;
            r_ovf    <= '0;
        end else if (w_dump) begin
            r_tdata  <= {w_y_q, w_y_i};
            r_tvalid <= 1'b1;
            if (r_tvalid && !m_axis.tready && (r_ovf != 16'hFFFF))
                r_ovf <= r_ovf + 16'd1;
        end else if (m_axis.tready) begin
            r_tvalid <= 1'b0;
        end
    end

    assign s_axis.tready     = w_ready;
    assign s_axis_ref.tready = w_ready;
    assign m_axis.tdata      = r_tdata;
    assign m_axis.tvalid     = r_tvalid;
    assign overflow_cnt      = r_ovf;
endmodule

// File: tb/tb_iq_demodulator.sv
// Directed bench for iq_demodulator with default parameters.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_iq_demodulator;
    logic        clk;
    logic        rstn;
    logic [15:0] ovf;
    int          tests;
    int          fails;

    iq_demodulator_if #(.W(16)) s_if ();
    iq_demodulator_if #(.W(16)) r_if ();
    iq_demodulator_if #(.W(32)) m_if ();

    iq_demodulator dut (
        .clk          (clk),
        .rstn         (rstn),
        .s_axis       (s_if),
        .s_axis_ref   (r_if),
        .m_axis       (m_if),
        .overflow_cnt (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input int x, input int c, input int s, input logic v, input logic rv);
        s_if.tdata  = 16'(x);
        r_if.tdata  = {8'(s), 8'(c)};
        s_if.tvalid = v;
        r_if.tvalid = rv;
    endtask

    task automatic chk_iq(input string tag, input int ei, input int eq);
        chk({tag, "_vld"}, int'(m_if.tvalid), 1);
        chk({tag, "_I"}, int'($signed(m_if.tdata[15:0])), ei);
        chk({tag, "_Q"}, int'($signed(m_if.tdata[31:16])), eq);
    endtask

    // One full block of 10 back-to-back samples with tready high.
    task automatic blk(input string tag, input int x, input int c, input int s,
                       input int ei, input int eq);
        for (int k = 0; k < 10; k++) begin
            drive(x, c, s, 1'b1, 1'b1);
            cyc();
        end
        drive(0, c, s, 1'b0, 1'b1);
        chk({tag, "_early"}, int'(m_if.tvalid), 0);
        cyc();
        chk_iq(tag, ei, eq);
        cyc();
        chk({tag, "_drop"}, int'(m_if.tvalid), 0);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rstn  = 1'b0;
        m_if.tready = 1'b1;
        drive(0, 0, 0, 1'b0, 1'b1);
        @(negedge clk);
        repeat (3) cyc();

        // Reset state
        chk("rst_tready", int'(s_if.tready), 0);
        chk("rst_tvalid", int'(m_if.tvalid), 0);
        chk("rst_tdata",  int'(m_if.tdata), 0);
        chk("rst_ovf",    int'(ovf), 0);
        rstn = 1'b1;
        cyc();
        chk("run_tready", int'(s_if.tready), 1);

        // DC in-phase: 30 samples, results two edges after each 10th accept
        for (int k = 1; k <= 32; k++) begin
            drive(1000, 64, 0, (k <= 30), 1'b1);
            cyc();
            chk($sformatf("dc_vld_%0d", k), int'(m_if.tvalid),
                (k == 11 || k == 21 || k == 31) ? 1 : 0);
            if (k == 11 || k == 21 || k == 31)
                chk_iq($sformatf("dc_%0d", k), 2500, 0);
        end

        // Negative / quadrature / floor rounding / saturation
        blk("quad",  -1000,   0,   64,     0, -2500);
        blk("floor",    -1,   1,    1,    -1,    -1);
        blk("sat",   32767, 127, -128, 32767, -32768);

        // Reference gating: ref invalid for 3 cycles after the 4th sample
        for (int k = 1; k <= 13; k++) begin
            drive(1000, 64, 0, 1'b1, !(k >= 5 && k <= 7));
            #1;
            chk($sformatf("gate_rdy_%0d", k), int'(s_if.tready), (k >= 5 && k <= 7) ? 0 : 1);
            cyc();
        end
        drive(0, 64, 0, 1'b0, 1'b1);
        chk("gate_early", int'(m_if.tvalid), 0);
        cyc();
        chk_iq("gate", 2500, 0);
        cyc();
        chk("gate_drop", int'(m_if.tvalid), 0);

        // Backpressure across two dumps: second result overwrites, one overflow
        m_if.tready = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            drive((k <= 10) ? 1000 : 2000, 64, 0, 1'b1, 1'b1);
            cyc();
            if (k == 11) begin
                chk_iq("bp_first", 2500, 0);
                chk("bp_ovf0", int'(ovf), 0);
            end
            if (k == 20) chk_iq("bp_hold", 2500, 0);
        end
        drive(0, 64, 0, 1'b0, 1'b1);
        cyc();
        chk_iq("bp_over", 5000, 0);
        chk("bp_ovf1", int'(ovf), 1);
        m_if.tready = 1'b1;
        #1;
        chk("bp_hs_vld", int'(m_if.tvalid), 1);
        cyc();
        chk("bp_after", int'(m_if.tvalid), 0);
        chk("bp_ovf_keep", int'(ovf), 1);

        // Dump coinciding with tready: replace pending, no overflow
        m_if.tready = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            drive((k <= 10) ? 1000 : -1000, 64, 0, 1'b1, 1'b1);
            cyc();
            if (k == 11) chk_iq("co_pend", 2500, 0);
        end
        drive(0, 64, 0, 1'b0, 1'b1);
        m_if.tready = 1'b1;
        cyc();
        chk_iq("co_new", -2500, 0);
        chk("co_ovf", int'(ovf), 1);
        cyc();
        chk("co_after", int'(m_if.tvalid), 0);

        // Reset mid-block: partial block discarded
        for (int k = 0; k < 4; k++) begin
            drive(32767, 127, 0, 1'b1, 1'b1);
            cyc();
        end
        drive(0, 127, 0, 1'b0, 1'b1);
        rstn = 1'b0;
        cyc();
        chk("mid_rst_tready", int'(s_if.tready), 0);
        chk("mid_rst_tvalid", int'(m_if.tvalid), 0);
        chk("mid_rst_tdata",  int'(m_if.tdata), 0);
        chk("mid_rst_ovf",    int'(ovf), 0);
        rstn = 1'b1;
        cyc();
        chk("mid_run", int'(s_if.tready), 1);
        blk("mid", 1000, 64, 0, 2500, 0);
        chk("mid_ovf", int'(ovf), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
